axi_read_arbiter: RTL



---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_pick.sv | 31 +++
 rtl/axi_read_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port AXI read arbiter.
// Used by arb_pick and axi_read_arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-way grant picker: fixed priority (LSU over IFU) by default,
// round-robin on ties when AXI_ARB_RR_EN is defined.
module arb_pick
    import arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef AXI_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic       grant
);

`ifdef AXI_ARB_RR_EN
    // A tie goes to the port that was not served last.
    always_comb begin
        grant = REQ_IFU;
        if (&req)
            grant = ~last_grant;
        else if (req[REQ_LSU])
            grant = REQ_LSU;
    end
`else
    // LSU always wins when it is requesting.
    always_comb begin
        grant = REQ_IFU;
        if (req[REQ_LSU])
            grant = REQ_LSU;
    end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port between the fetch unit (m0) and the LSU (m1).
// Optional macro AXI_ARB_RR_EN selects round-robin arbitration.
module axi_read_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,

    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic [ID_W-1:0]   m0_rid,

    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic [ID_W-1:0]   m1_rid,

    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W-1:0]   s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic [ID_W-1:0]   s_rid,

    output logic              o_busy
);

    arb_state_t state;
    logic       owner;
    logic       pick;
    logic       in_addr;
    logic       in_data;
    logic       ar_done;
    logic       r_done;

`ifdef AXI_ARB_RR_EN
    logic       last_grant;
`endif

    arb_pick u_pick (
        .req        ({m1_arvalid, m0_arvalid}),
`ifdef AXI_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant      (pick)
    );

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);
    assign ar_done = s_arvalid & s_arready;
    assign r_done  = s_rvalid & s_rready & s_rlast;
    assign o_busy  = (state != IDLE);

    // Owner's address channel goes to the slave while in ADDR.
    assign s_arvalid = in_addr & (owner ? m1_arvalid : m0_arvalid);
    assign s_araddr  = owner ? m1_araddr  : m0_araddr;
    assign s_arid    = owner ? m1_arid    : m0_arid;
    assign s_arlen   = owner ? m1_arlen   : m0_arlen;
    assign s_arsize  = owner ? m1_arsize  : m0_arsize;
    assign s_arburst = owner ? m1_arburst : m0_arburst;

    assign m0_arready = in_addr & (owner == REQ_IFU) & s_arready;
    assign m1_arready = in_addr & (owner == REQ_LSU) & s_arready;

    // Only rvalid is steered; the data fields are broadcast.
    assign m0_rvalid = in_data & (owner == REQ_IFU) & s_rvalid;
    assign m1_rvalid = in_data & (owner == REQ_LSU) & s_rvalid;
    assign s_rready  = in_data & (owner ? m1_rready : m0_rready);

    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m0_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;
    assign m1_rid   = s_rid;

    // Burst ownership FSM: grant, address phase, data phase.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            owner <= REQ_IFU;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_arvalid | m1_arvalid) begin
                        owner <= pick;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_done)
                        state <= DATA;
                end
                DATA: begin
                    if (r_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_ARB_RR_EN
    // Remember who finished last so the next tie goes the other way.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            last_grant <= REQ_LSU;
        else if (in_data & r_done)
            last_grant <= owner;
    end
`endif

endmodule
